inner_product_seq: RTL and testbench
====================================

INNER_PRODUCT_SEQ -- requirements
Module: inner_product_seq

Interface
REQ-001 The block SHALL have parameter NUM_ELEMENTS, default 4, giving the maximum vector length; legal range is 1..64.
REQ-002 The block SHALL have parameter LEN_WIDTH, default $clog2(NUM_ELEMENTS+1), giving the width of len.
REQ-003 The block SHALL have port clk, input, 1, the single clock, rising edge.
REQ-004 The block SHALL have port rst, input, 1, reset, asynchronous and active-low.
REQ-005 The block SHALL have port row, input, 32*NUM_ELEMENTS, IEEE-754 single elements; element k is at bits [32k+31:32k].
REQ-006 The block SHALL have port column, input, 32*NUM_ELEMENTS, IEEE-754 single elements, packed like row.
REQ-007 The block SHALL have port len, input, LEN_WIDTH, the active element count, sampled at accept.
REQ-008 The block SHALL have port acc_en, input, 1, which selects accumulation onto the previous result; sampled at accept.
REQ-009 The block SHALL have ports row_i_stb and column_i_stb, inputs, 1, the operand-valid strobes.
REQ-010 The block SHALL have ports row_i_ack and column_i_ack, outputs, 1, the operand-accept indications.
REQ-011 The block SHALL have ports out (output, 32, result), out_o_stb (output, 1, result valid) and out_o_ack (input, 1, result taken).
REQ-012 The block SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-013 The block SHALL instantiate exactly one codebase multiplier and one codebase adder (stb/ack float units), time-shared across all elements.
REQ-014 Both units SHALL receive the inverted rst as their active-high reset; no per-operation unit resets are permitted.
REQ-015 The FSM SHALL have states IDLE, MUL_REQ, MUL_WAIT, ADD_REQ, ADD_WAIT, OUT.
REQ-016 In IDLE, row_i_ack and column_i_ack SHALL both be 1; in all other states they SHALL be 0.
REQ-017 Accept SHALL occur on a rising edge where the state is IDLE and row_i_stb, column_i_stb and row_i_ack are all 1.
- row, column, len and acc_en are captured into internal registers.
- Index is set to 0.
- The sum is set to the result register if acc_en=1, else 0x00000000.
REQ-018 If the captured len is 0 at accept, the next state SHALL be OUT; otherwise it SHALL be MUL_REQ.
REQ-019 A captured len greater than NUM_ELEMENTS SHALL be saturated to NUM_ELEMENTS.
REQ-020 In MUL_REQ, the block SHALL drive the multiplier a/b with captured element[index] and hold both stb high until the corresponding multiplier ack is seen, then go to MUL_WAIT.
REQ-021 In MUL_WAIT, on multiplier z_stb the block SHALL latch the product, pulse z_ack for exactly one cycle, and go to ADD_REQ.
REQ-022 In ADD_REQ, the block SHALL drive adder a=product and b=sum, holding both stb high until both acks are seen.
REQ-023 In ADD_WAIT, on adder z_stb the block SHALL load the sum from the adder, pulse z_ack for one cycle, and increment index.
- If the new index equals len, the next state is OUT.
- Otherwise the next state is MUL_REQ.
REQ-024 Element order SHALL be index 0 first, ascending; only elements below len are used.
REQ-025 On entry to OUT, the result register SHALL be loaded with the sum, and out SHALL equal the result register at all times.
REQ-026 In OUT, out_o_stb SHALL be 1 and out SHALL be stable until an edge with out_o_ack=1; at that edge out_o_stb goes to 0 and the state returns to IDLE.
REQ-027 out_o_ack SHALL be ignored outside OUT.
REQ-028 If out_o_ack is already high on entry to OUT, out_o_stb SHALL be high for exactly one cycle.
REQ-029 Operand strobes asserted while busy=1 SHALL be ignored, with no capture.
REQ-030 The block SHALL add no more than one cycle of FSM overhead per unit handshake beyond the unit latencies.

Reset
REQ-031 While rst=0, the state SHALL be IDLE, out and the result register 0x00000000, out_o_stb 0, busy 0, row_i_ack and column_i_ack 1, all unit strobes and acks 0, and index 0.
REQ-032 Reset asserted mid-operation SHALL abort the operation immediately; after release, no stale out_o_stb and no stale unit handshake SHALL occur.

Verification
REQ-033 Case len=4, row={1.0,2.0,3.0,4.0}, column all 1.0, acc_en=0: out=0x41200000 (10.0), and out_o_stb held until out_o_ack.
REQ-034 Case acc_en=1 applied after the previous case, with row={2.0,0,0,0}, column={0.5,0,0,0}, len=1: out=0x41300000 (11.0).
REQ-035 Case len=0, acc_en=0: out_o_stb is asserted with out=0x00000000 and no multiplier strobe is driven.
REQ-036 Case out_o_ack held low for 20 cycles: out and out_o_stb remain constant, and new operand strobes are not acked.
REQ-037 Case rst pulsed low during MUL_WAIT: all outputs take their reset values; the next transaction, len=2 with row={3.0,1.0}, column={2.0,-1.0}, gives out=0x40A00000 (5.0).
REQ-038 Case len=NUM_ELEMENTS+1 (where representable): saturated to NUM_ELEMENTS; compare against the golden model over random finite operands.

Source files
------------

// File: rtl/inner_product_seq.sv
// Sequential IEEE-754 single dot product: one shared stb/ack multiplier and adder, ~4 cycles per element.
// Operands are acked only in IDLE; the result is held with out_o_stb until out_o_ack.

module fp_mul (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        a_stb,
    input  logic        b_stb,
    output logic        a_ack,
    output logic        b_ack,
    output logic [31:0] z,
    output logic        z_stb,
    input  logic        z_ack
);
    // Round-to-nearest-even; subnormal inputs and results flush to signed zero.
    function automatic logic [31:0] fmul(input logic [31:0] x, input logic [31:0] y);
        logic              s;
        logic [47:0]       p;
        logic [24:0]       m;
        logic              g;
        logic              st;
        logic signed [9:0] e;
        s = x[31] ^ y[31];
        if ((x[30:23] == 8'hff && x[22:0] != 23'd0) || (y[30:23] == 8'hff && y[22:0] != 23'd0))
            return 32'h7fc00000;
        if (x[30:23] == 8'hff || y[30:23] == 8'hff)
            return (x[30:23] == 8'd0 || y[30:23] == 8'd0) ? 32'h7fc00000 : {s, 8'hff, 23'd0};
        if (x[30:23] == 8'd0 || y[30:23] == 8'd0)
            return {s, 31'd0};
        p = {24'd0, 1'b1, x[22:0]} * {24'd0, 1'b1, y[22:0]};
        e = $signed({2'b00, x[30:23]}) + $signed({2'b00, y[30:23]}) - 10'sd127;
        if (p[47]) begin
            m  = {1'b0, p[47:24]};
            g  = p[23];
            st = |p[22:0];
            e  = e + 10'sd1;
        end else begin
            m  = {1'b0, p[46:23]};
            g  = p[22];
            st = |p[21:0];
        end
        if (g && (st || m[0])) m = m + 25'd1;
        if (m[24]) e = e + 10'sd1;
        if (e >= 10'sd255) return {s, 8'hff, 23'd0};
        if (e <= 10'sd0) return {s, 31'd0};
        return {s, e[7:0], m[24] ? m[23:1] : m[22:0]};
    endfunction

    assign a_ack = a_stb & b_stb & ~z_stb;
    assign b_ack = a_ack;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            z     <= 32'd0;
            z_stb <= 1'b0;
        end else if (a_ack) begin
            z     <= fmul(a, b);
            z_stb <= 1'b1;
        end else if (z_ack) begin
            z_stb <= 1'b0;
        end
    end
endmodule

module fp_add (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        a_stb,
    input  logic        b_stb,
    output logic        a_ack,
    output logic        b_ack,
    output logic [31:0] z,
    output logic        z_stb,
    input  logic        z_ack
);
    // Three guard bits with sticky folded into bit 0 are enough for correct RNE.
    function automatic logic [31:0] fadd(input logic [31:0] x, input logic [31:0] y);
        logic [31:0]       l;
        logic [30:0]       sm;
        logic [26:0]       ml;
        logic [26:0]       ms;
        logic [27:0]       acc;
        logic [7:0]        d;
        logic              sticky;
        logic [24:0]       m;
        logic              g;
        logic              st;
        logic signed [9:0] e;
        int                lz;
        if ((x[30:23] == 8'hff && x[22:0] != 23'd0) || (y[30:23] == 8'hff && y[22:0] != 23'd0))
            return 32'h7fc00000;
        if (x[30:23] == 8'hff && y[30:23] == 8'hff) return (x[31] == y[31]) ? x : 32'h7fc00000;
        if (x[30:23] == 8'hff) return x;
        if (y[30:23] == 8'hff) return y;
        if (x[30:23] == 8'd0 && y[30:23] == 8'd0) return {x[31] & y[31], 31'd0};
        if (x[30:23] == 8'd0) return y;
        if (y[30:23] == 8'd0) return x;
        if (x[30:0] >= y[30:0]) begin
            l  = x;
            sm = y[30:0];
        end else begin
            l  = y;
            sm = x[30:0];
        end
        d  = l[30:23] - sm[30:23];
        ml = {1'b1, l[22:0], 3'b000};
        ms = {1'b1, sm[22:0], 3'b000};
        if (d > 8'd26) begin
            ms = 27'd1;
        end else begin
            sticky = |(ms & ((27'd1 << d) - 27'd1));
            ms     = (ms >> d) | {26'd0, sticky};
        end
        e = $signed({2'b00, l[30:23]});
        if (x[31] == y[31]) begin
            acc = {1'b0, ml} + {1'b0, ms};
            if (acc[27]) begin
                acc = {1'b0, acc[27:2], acc[1] | acc[0]};
                e   = e + 10'sd1;
            end
        end else begin
            acc = {1'b0, ml} - {1'b0, ms};
            if (acc == 28'd0) return 32'd0;
            lz = 0;
            for (int i = 0; i <= 26; i++) if (acc[i]) lz = 26 - i;
            acc = acc << lz;
            e   = e - $signed(10'(lz));
        end
        m  = {1'b0, acc[26:3]};
        g  = acc[2];
        st = |acc[1:0];
        if (g && (st || m[0])) m = m + 25'd1;
        if (m[24]) e = e + 10'sd1;
        if (e >= 10'sd255) return {l[31], 8'hff, 23'd0};
        if (e <= 10'sd0) return {l[31], 31'd0};
        return {l[31], e[7:0], m[24] ? m[23:1] : m[22:0]};
    endfunction

    assign a_ack = a_stb & b_stb & ~z_stb;
    assign b_ack = a_ack;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            z     <= 32'd0;
            z_stb <= 1'b0;
        end else if (a_ack) begin
            z     <= fadd(a, b);
            z_stb <= 1'b1;
        end else if (z_ack) begin
            z_stb <= 1'b0;
        end
    end
endmodule

module inner_product_seq #(
    parameter int NUM_ELEMENTS = 4,
    parameter int LEN_WIDTH    = $clog2(NUM_ELEMENTS + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [32*NUM_ELEMENTS-1:0] row,
    input  logic [32*NUM_ELEMENTS-1:0] column,
    input  logic [LEN_WIDTH-1:0]       len,
    input  logic                       acc_en,
    input  logic                       row_i_stb,
    input  logic                       column_i_stb,
    output logic                       row_i_ack,
    output logic                       column_i_ack,
    output logic [31:0]                out,
    output logic                       out_o_stb,
    input  logic                       out_o_ack,
    output logic                       busy
);
    typedef enum logic [2:0] {IDLE, MUL_REQ, MUL_WAIT, ADD_REQ, ADD_WAIT, OUT} state_t;

    state_t                     state_q, state_d;
    logic [32*NUM_ELEMENTS-1:0] row_q, column_q;
    logic [LEN_WIDTH-1:0]       len_q, len_sat, idx_q, idx_next;
    logic [31:0]                prod_q, sum_q, result_q;
    logic [31:0]                row_elem, column_elem;
    logic                       accept, unit_reset;
    logic                       mul_stb, mul_a_ack, mul_b_ack, mul_z_stb, mul_z_ack;
    logic                       add_stb, add_a_ack, add_b_ack, add_z_stb, add_z_ack;
    logic [31:0]                mul_z, add_z;

    assign unit_reset = ~rst;
    assign len_sat    = (len > LEN_WIDTH'(NUM_ELEMENTS)) ? LEN_WIDTH'(NUM_ELEMENTS) : len;
    assign idx_next   = idx_q + LEN_WIDTH'(1);
    assign accept     = (state_q == IDLE) && row_i_stb && column_i_stb && row_i_ack;
    assign out        = result_q;

    always_comb begin
        row_elem    = 32'd0;
        column_elem = 32'd0;
        for (int k = 0; k < NUM_ELEMENTS; k++) begin
            if (idx_q == LEN_WIDTH'(k)) begin
                row_elem    = row_q[32*k +: 32];
                column_elem = column_q[32*k +: 32];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        row_i_ack    = 1'b0;
        column_i_ack = 1'b0;
        mul_stb      = 1'b0;
        mul_z_ack    = 1'b0;
        add_stb      = 1'b0;
        add_z_ack    = 1'b0;
        out_o_stb    = 1'b0;
        busy         = 1'b1;
        case (state_q)
            IDLE: begin
                row_i_ack    = 1'b1;
                column_i_ack = 1'b1;
                busy         = 1'b0;
                if (accept) state_d = (len_sat == '0) ? OUT : MUL_REQ;
            end
            MUL_REQ: begin
                mul_stb = 1'b1;
                if (mul_a_ack && mul_b_ack) state_d = MUL_WAIT;
            end
            MUL_WAIT: begin
                mul_z_ack = mul_z_stb;
                if (mul_z_stb) state_d = ADD_REQ;
            end
            ADD_REQ: begin
                add_stb = 1'b1;
                if (add_a_ack && add_b_ack) state_d = ADD_WAIT;
            end
            ADD_WAIT: begin
                add_z_ack = add_z_stb;
                if (add_z_stb) state_d = (idx_next == len_q) ? OUT : MUL_REQ;
            end
            OUT: begin
                out_o_stb = 1'b1;
                if (out_o_ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // result_q is written only on the transition into OUT, so out is stable while OUT waits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_q    <= '0;
            column_q <= '0;
            len_q    <= '0;
            idx_q    <= '0;
            prod_q   <= 32'd0;
            sum_q    <= 32'd0;
            result_q <= 32'd0;
        end else begin
            case (state_q)
                IDLE: if (accept) begin
                    row_q    <= row;
                    column_q <= column;
                    len_q    <= len_sat;
                    idx_q    <= '0;
                    sum_q    <= acc_en ? result_q : 32'd0;
                    if (len_sat == '0 && !acc_en) result_q <= 32'd0;
                end
                MUL_WAIT: if (mul_z_stb) prod_q <= mul_z;
                ADD_WAIT: if (add_z_stb) begin
                    sum_q <= add_z;
                    idx_q <= idx_next;
                    if (idx_next == len_q) result_q <= add_z;
                end
                default: ;
            endcase
        end
    end

    fp_mul u_mul (
        .clk   (clk),
        .reset (unit_reset),
        .a     (row_elem),
        .b     (column_elem),
        .a_stb (mul_stb),
        .b_stb (mul_stb),
        .a_ack (mul_a_ack),
        .b_ack (mul_b_ack),
        .z     (mul_z),
        .z_stb (mul_z_stb),
        .z_ack (mul_z_ack)
    );

    fp_add u_add (
        .clk   (clk),
        .reset (unit_reset),
        .a     (prod_q),
        .b     (sum_q),
        .a_stb (add_stb),
        .b_stb (add_stb),
        .a_ack (add_a_ack),
        .b_ack (add_b_ack),
        .z     (add_z),
        .z_stb (add_z_stb),
        .z_ack (add_z_ack)
    );
endmodule

// File: tb/tb_inner_product_seq.sv
// Directed and small-integer random checks of inner_product_seq: sums, accumulation,
// len 0, output hold, early ack, rounding, mid-operation reset and len saturation.

module tb_inner_product_seq;
    localparam int N  = 4;
    localparam int LW = $clog2(N + 1);

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [32*N-1:0] row = '0;
    logic [32*N-1:0] column = '0;
    logic [LW-1:0]   len = '0;
    logic            acc_en = 1'b0;
    logic            row_i_stb = 1'b0;
    logic            column_i_stb = 1'b0;
    logic            out_o_ack = 1'b0;
    logic            row_i_ack, column_i_ack, out_o_stb, busy;
    logic [31:0]     out;

    int pass_cnt = 0;
    int total_cnt = 0;

    inner_product_seq #(.NUM_ELEMENTS(N), .LEN_WIDTH(LW)) dut (
        .clk          (clk),
        .rst          (rst),
        .row          (row),
        .column       (column),
        .len          (len),
        .acc_en       (acc_en),
        .row_i_stb    (row_i_stb),
        .column_i_stb (column_i_stb),
        .row_i_ack    (row_i_ack),
        .column_i_ack (column_i_ack),
        .out          (out),
        .out_o_stb    (out_o_stb),
        .out_o_ack    (out_o_ack),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] i2f(input int v);
        int          m;
        int          e;
        logic        sgn;
        logic [7:0]  ex;
        logic [22:0] fr;
        if (v == 0) return 32'd0;
        sgn = (v < 0);
        m   = sgn ? -v : v;
        e   = 0;
        while ((m >> (e + 1)) != 0) e++;
        ex = 8'(e + 127);
        fr = 23'(m << (23 - e));
        return {sgn, ex, fr};
    endfunction

    function automatic logic [31:0] scale_down(input logic [31:0] f, input int n);
        if (f[30:23] == 8'd0) return f;
        return {f[31], f[30:23] - 8'(n), f[22:0]};
    endfunction

    // Returns at the first negedge where out_o_stb is seen, or after the cycle budget.
    task automatic run_op(input logic [32*N-1:0] r, input logic [32*N-1:0] c, input logic [LW-1:0] l,
                          input logic acc, output logic [31:0] res, output logic got, output logic ms);
        @(negedge clk);
        row = r; column = c; len = l; acc_en = acc;
        row_i_stb = 1'b1; column_i_stb = 1'b1;
        @(negedge clk);
        row_i_stb = 1'b0; column_i_stb = 1'b0;
        got = 1'b0; ms = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (dut.mul_stb) ms = 1'b1;
            if (out_o_stb) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        res = out;
    endtask

    task automatic ack_out();
        out_o_ack = 1'b1;
        @(negedge clk);
        out_o_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; row_i_stb = 1'b1; column_i_stb = 1'b1;
        repeat (2) @(negedge clk);
        total_cnt++;
        if ({out, out_o_stb, busy, row_i_ack, column_i_ack} !== {32'd0, 1'b0, 1'b0, 1'b1, 1'b1})
            $display("FAIL reset_state: out=%h stb=%b busy=%b acks=%b%b, required 00000000 0 0 11",
                     out, out_o_stb, busy, row_i_ack, column_i_ack);
        else pass_cnt++;
        row_i_stb = 1'b0; column_i_stb = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total_cnt++;
        if ({busy, out_o_stb} !== 2'b00) $display("FAIL reset_release: busy=%b stb=%b, required 0 0", busy, out_o_stb);
        else pass_cnt++;
    endtask

    task automatic test_basic();
        logic [31:0] res; logic got, ms;
        run_op({32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000}, {4{32'h3F800000}}, LW'(4), 1'b0, res, got, ms);
        total_cnt++;
        if ({got, ms, res} !== {2'b11, 32'h41200000})
            $display("FAIL basic_sum: got=%b mul=%b out=%h, required 1 1 41200000", got, ms, res);
        else pass_cnt++;
        repeat (3) @(negedge clk);
        total_cnt++;
        if ({out_o_stb, out} !== {1'b1, 32'h41200000})
            $display("FAIL basic_hold: stb=%b out=%h, required 1 41200000", out_o_stb, out);
        else pass_cnt++;
        ack_out();
        total_cnt++;
        if ({out_o_stb, busy} !== 2'b00) $display("FAIL basic_release: stb=%b busy=%b, required 0 0", out_o_stb, busy);
        else pass_cnt++;
    endtask

    task automatic test_accumulate();
        logic [31:0] res; logic got, ms;
        run_op({96'd0, 32'h40000000}, {96'd0, 32'h3F000000}, LW'(1), 1'b1, res, got, ms);
        total_cnt++;
        if ({got, ms, res} !== {2'b11, 32'h41300000})
            $display("FAIL accumulate: got=%b mul=%b out=%h, required 1 1 41300000", got, ms, res);
        else pass_cnt++;
        ack_out();
    endtask

    task automatic test_len_zero();
        logic [31:0] res; logic got, ms;
        run_op({4{32'h40400000}}, {4{32'h40400000}}, LW'(0), 1'b0, res, got, ms);
        total_cnt++;
        if ({got, ms, res} !== {2'b10, 32'h00000000})
            $display("FAIL len_zero: got=%b mul=%b out=%h, required 1 0 00000000", got, ms, res);
        else pass_cnt++;
        ack_out();
    endtask

    task automatic test_hold();
        logic [31:0] res; logic got, ms;
        run_op({64'd0, 32'h40000000, 32'h3F800000}, {64'd0, 32'h40000000, 32'h40000000}, LW'(2), 1'b0, res, got, ms);
        total_cnt++;
        if ({got, ms, res} !== {2'b11, 32'h40C00000})
            $display("FAIL hold_sum: got=%b mul=%b out=%h, required 1 1 40C00000", got, ms, res);
        else pass_cnt++;
        row = {4{32'h41000000}}; column = {4{32'h41000000}}; len = LW'(4);
        row_i_stb = 1'b1; column_i_stb = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            total_cnt++;
            if ({out_o_stb, out, row_i_ack, column_i_ack} !== {1'b1, 32'h40C00000, 2'b00})
                $display("FAIL hold_cycle_%0d: stb=%b out=%h acks=%b%b, required 1 40C00000 00",
                         i, out_o_stb, out, row_i_ack, column_i_ack);
            else pass_cnt++;
        end
        row_i_stb = 1'b0; column_i_stb = 1'b0;
        ack_out();
        @(negedge clk);
        total_cnt++;
        if ({busy, out} !== {1'b0, 32'h40C00000})
            $display("FAIL hold_no_capture: busy=%b out=%h, required 0 40C00000", busy, out);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] res; logic got, ms;
        out_o_ack = 1'b1;
        run_op({96'd0, 32'h40400000}, {96'd0, 32'h40400000}, LW'(1), 1'b0, res, got, ms);
        total_cnt++;
        if ({got, ms, res} !== {2'b11, 32'h41100000})
            $display("FAIL early_ack_sum: got=%b mul=%b out=%h, required 1 1 41100000", got, ms, res);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if ({out_o_stb, busy} !== 2'b00) $display("FAIL early_ack_pulse: stb=%b busy=%b, required 0 0", out_o_stb, busy);
        else pass_cnt++;
        out_o_ack = 1'b0;
        run_op({96'd0, 32'h3F800000}, {96'd0, 32'h3F800000}, LW'(1), 1'b1, res, got, ms);
        total_cnt++;
        if ({got, ms, res} !== {2'b11, 32'h41200000})
            $display("FAIL back_to_back: got=%b mul=%b out=%h, required 1 1 41200000", got, ms, res);
        else pass_cnt++;
        ack_out();
    endtask

    task automatic test_rounding();
        logic [31:0] res; logic got, ms;
        run_op({64'd0, 32'h33800000, 32'h3F800000}, {64'd0, {2{32'h3F800000}}}, LW'(2), 1'b0, res, got, ms);
        total_cnt++;
        if ({got, ms, res} !== {2'b11, 32'h3F800000})
            $display("FAIL round_tie_even: got=%b mul=%b out=%h, required 1 1 3F800000", got, ms, res);
        else pass_cnt++;
        ack_out();
        run_op({64'd0, 32'h33C00000, 32'h3F800000}, {64'd0, {2{32'h3F800000}}}, LW'(2), 1'b0, res, got, ms);
        total_cnt++;
        if ({got, ms, res} !== {2'b11, 32'h3F800001})
            $display("FAIL round_up: got=%b mul=%b out=%h, required 1 1 3F800001", got, ms, res);
        else pass_cnt++;
        ack_out();
    endtask

    task automatic test_reset_mid();
        logic [31:0] res; logic got, ms, stale;
        @(negedge clk);
        row = {4{32'h3F800000}}; column = {4{32'h3F800000}}; len = LW'(4); acc_en = 1'b0;
        row_i_stb = 1'b1; column_i_stb = 1'b1;
        @(negedge clk);
        row_i_stb = 1'b0; column_i_stb = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        total_cnt++;
        if ({out, out_o_stb, busy, row_i_ack, column_i_ack} !== {32'd0, 1'b0, 1'b0, 1'b1, 1'b1})
            $display("FAIL reset_mid_outputs: out=%h stb=%b busy=%b acks=%b%b, required 00000000 0 0 11",
                     out, out_o_stb, busy, row_i_ack, column_i_ack);
        else pass_cnt++;
        total_cnt++;
        if ({dut.mul_stb, dut.mul_z_stb, dut.add_stb, dut.add_z_stb} !== 4'b0000)
            $display("FAIL reset_mid_units: strobes=%b%b%b%b, required 0000",
                     dut.mul_stb, dut.mul_z_stb, dut.add_stb, dut.add_z_stb);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b1;
        stale = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_o_stb || busy || dut.mul_z_stb || dut.add_z_stb) stale = 1'b1;
        end
        total_cnt++;
        if (stale !== 1'b0) $display("FAIL reset_mid_stale: stale activity=%b, required 0", stale);
        else pass_cnt++;
        run_op({64'd0, 32'h3F800000, 32'h40400000}, {64'd0, 32'hBF800000, 32'h40000000}, LW'(2), 1'b0, res, got, ms);
        total_cnt++;
        if ({got, ms, res} !== {2'b11, 32'h40A00000})
            $display("FAIL reset_mid_next: got=%b mul=%b out=%h, required 1 1 40A00000", got, ms, res);
        else pass_cnt++;
        ack_out();
    endtask

    // Elements are k/2 with small integer k, so every partial sum is exact and the
    // golden value is the integer sum of kr*kc scaled by 1/4.
    task automatic test_saturate();
        logic [32*N-1:0] r, c;
        logic [LW-1:0]   l;
        logic [31:0]     res, exp_v;
        logic            got, ms;
        int              s, kr, kc, n;
        for (int t = 0; t < 8; t++) begin
            s = 0;
            l = (t < N) ? LW'(t + 1) : ((t % 2 == 0) ? LW'(N + 1) : LW'((1 << LW) - 1));
            n = (int'(l) > N) ? N : int'(l);
            for (int k = 0; k < N; k++) begin
                kr = int'($urandom_range(32)) - 16;
                kc = int'($urandom_range(32)) - 16;
                r[32*k +: 32] = scale_down(i2f(kr), 1);
                c[32*k +: 32] = scale_down(i2f(kc), 1);
                if (k < n) s += kr * kc;
            end
            exp_v = scale_down(i2f(s), 2);
            run_op(r, c, l, 1'b0, res, got, ms);
            total_cnt++;
            if ({got, ms, res} !== {2'b11, exp_v})
                $display("FAIL len_sat_%0d (len=%0d): got=%b mul=%b out=%h, required 1 1 %h", t, l, got, ms, res, exp_v);
            else pass_cnt++;
            ack_out();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_accumulate();
        test_len_zero();
        test_hold();
        test_back_to_back();
        test_rounding();
        test_reset_mid();
        test_saturate();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
